// File: rtl/registrador_paralelo_pkg.sv
// Shared constants for the parallel holding register.
// Optional edge-triggered load is selected with macro LOAD_EDGE_EN.
package registrador_pkg;
    localparam int DEFAULT_BITS = 8;
endpackage

// File: rtl/registrador_paralelo_if.sv
// Bus between a producer of words/commands and the holding register.
// The master drives data and commands; the slave returns the stored word and its valid flag.
interface registrador_paralelo_if
    import registrador_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
);
    logic [BITS-1:0] in;
    logic            load;
    logic            clr;
    logic [BITS-1:0] out;
    logic            valid;

    modport master (
        output in,
        output load,
        output clr,
        input  out,
        input  valid
    );

    modport slave (
        input  in,
        input  load,
        input  clr,
        output out,
        output valid
    );
endinterface

// File: rtl/registrador_paralelo_detector_borda.sv
// Single-bit synchronous rising-edge detector; rise is high in the cycle sig first reads high.
// The history flop resets to 1 so a signal already high at reset release is not seen as an edge.
module detector_borda (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);
    logic r_sig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig_q <= 1'b1;
        end else begin
            r_sig_q <= sig;
        end
    end

    assign rise = sig & ~r_sig_q;
endmodule

// File: rtl/registrador_paralelo.sv
// Parallel-in/parallel-out holding register, one-clock capture latency, priority rst > clr > load.
// Define LOAD_EDGE_EN to capture only on a rising edge of load instead of every cycle load is high.
module registrador_paralelo
    import registrador_pkg::*;
#(
    parameter int          BITS        = DEFAULT_BITS,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    registrador_paralelo_if.slave bus
);
    // Reset value is truncated or zero-extended to the data width.
    localparam logic [BITS-1:0] LP_RESET = BITS'(RESET_VALUE);

    logic            w_capture;
    logic [BITS-1:0] r_out;
    logic            r_valid;

`ifdef LOAD_EDGE_EN
    // The edge history keeps updating during clear cycles, so a load held through a clear stays dormant.
    detector_borda u_detector_borda (
        .clk  (clk),
        .rst  (rst),
        .sig  (bus.load),
        .rise (w_capture)
    );
`else
    assign w_capture = bus.load;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= LP_RESET;
            r_valid <= 1'b0;
        end else if (bus.clr) begin
            r_out   <= LP_RESET;
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_out   <= bus.in;
            r_valid <= 1'b1;
        end
    end

    assign bus.out   = r_out;
    assign bus.valid = r_valid;
endmodule

// File: tb/tb_registrador_paralelo.sv
// Directed self-checking bench: an 8-bit register plus 1-bit and 32-bit width variants.
module tb_registrador_paralelo;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    registrador_paralelo_if #(.BITS(8))  bus8  ();
    registrador_paralelo_if #(.BITS(1))  bus1  ();
    registrador_paralelo_if #(.BITS(32)) bus32 ();

    registrador_paralelo #(.BITS(8), .RESET_VALUE(0)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    registrador_paralelo #(.BITS(1), .RESET_VALUE(5)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    registrador_paralelo #(.BITS(32), .RESET_VALUE(5)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus8.in = 8'hFF;   bus8.load = 1'b1;  bus8.clr = 1'b0;
        bus1.in = 1'b0;    bus1.load = 1'b0;  bus1.clr = 1'b0;
        bus32.in = 32'h0;  bus32.load = 1'b0; bus32.clr = 1'b0;

        // Reset with load high and all-ones data
        tick();
        tick();
        check("rst_out",       {24'h0, bus8.out}, 32'h00);
        check("rst_valid",     {31'h0, bus8.valid}, 32'h0);
        check("rst_out_w1",    {31'h0, bus1.out}, 32'h1);
        check("rst_out_w32",   bus32.out, 32'h5);
        check("rst_valid_w32", {31'h0, bus32.valid}, 32'h0);

        rst = 1'b0;
        bus8.load = 1'b0;
        tick();
        check("post_rst_hold", {24'h0, bus8.out}, 32'h00);
        bus8.in = 8'hAA;
        tick();
        check("post_rst_in_chg",    {24'h0, bus8.out}, 32'h00);
        check("post_rst_valid",     {31'h0, bus8.valid}, 32'h0);

        // Basic load, then data change without load
        bus8.in = 8'h55; bus8.load = 1'b1;
        tick();
        check("load55_out",   {24'h0, bus8.out}, 32'h55);
        check("load55_valid", {31'h0, bus8.valid}, 32'h1);
        bus8.in = 8'hAA; bus8.load = 1'b0;
        tick();
        check("hold55", {24'h0, bus8.out}, 32'h55);

        // Reload, then keep load high while data steps
        bus8.in = 8'hAA; bus8.load = 1'b1;
        tick();
        check("reloadAA", {24'h0, bus8.out}, 32'hAA);
        bus8.in = 8'h01;
        tick();
`ifdef LOAD_EDGE_EN
        check("held_load_01", {24'h0, bus8.out}, 32'hAA);
`else
        check("held_load_01", {24'h0, bus8.out}, 32'h01);
`endif
        bus8.in = 8'h02;
        tick();
`ifdef LOAD_EDGE_EN
        check("held_load_02", {24'h0, bus8.out}, 32'hAA);
`else
        check("held_load_02", {24'h0, bus8.out}, 32'h02);
`endif

        // Width sweep: all-ones capture, then zero, then clear to reset value
        bus1.in = 1'b1;  bus1.load = 1'b1;
        bus32.in = 32'hFFFF_FFFF; bus32.load = 1'b1;
        bus8.load = 1'b0;
        tick();
        check("w1_ones",    {31'h0, bus1.out}, 32'h1);
        check("w1_valid",   {31'h0, bus1.valid}, 32'h1);
        check("w32_ones",   bus32.out, 32'hFFFF_FFFF);
        check("w32_valid",  {31'h0, bus32.valid}, 32'h1);
        bus1.load = 1'b0; bus32.load = 1'b0;
        tick();
        bus1.in = 1'b0;  bus1.load = 1'b1;
        bus32.in = 32'h0000_00A0; bus32.load = 1'b1;
        tick();
        check("w1_zero",  {31'h0, bus1.out}, 32'h0);
        check("w32_A0",   bus32.out, 32'h0000_00A0);
        bus1.load = 1'b0; bus1.clr = 1'b1;
        bus32.load = 1'b0; bus32.clr = 1'b1;
        tick();
        check("w1_clr",        {31'h0, bus1.out}, 32'h1);
        check("w1_clr_valid",  {31'h0, bus1.valid}, 32'h0);
        check("w32_clr",       bus32.out, 32'h5);
        bus1.clr = 1'b0; bus32.clr = 1'b0;

        // Clear beats a simultaneous load
        bus8.in = 8'h3C; bus8.load = 1'b1; bus8.clr = 1'b1;
        tick();
        check("clr_prio_out",   {24'h0, bus8.out}, 32'h00);
        check("clr_prio_valid", {31'h0, bus8.valid}, 32'h0);
        bus8.clr = 1'b0; bus8.load = 1'b0;
        tick();
        check("after_clr_hold", {24'h0, bus8.out}, 32'h00);
        bus8.in = 8'h77; bus8.load = 1'b1;
        tick();
        check("load77", {24'h0, bus8.out}, 32'h77);

        // Reset beats clear and load
        rst = 1'b1; bus8.clr = 1'b1; bus8.in = 8'h99;
        tick();
        check("rst_prio_out",   {24'h0, bus8.out}, 32'h00);
        check("rst_prio_valid", {31'h0, bus8.valid}, 32'h0);

        // Load held high through reset release
        bus8.clr = 1'b0; bus8.in = 8'hC3; bus8.load = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`ifdef LOAD_EDGE_EN
        check("load_thru_rst", {24'h0, bus8.out}, 32'h00);
        tick();
        check("load_thru_rst2", {24'h0, bus8.out}, 32'h00);
        bus8.load = 1'b0;
        tick();
        bus8.load = 1'b1;
        tick();
        check("edge_C3",       {24'h0, bus8.out}, 32'hC3);
        check("edge_C3_valid", {31'h0, bus8.valid}, 32'h1);
        bus8.in = 8'h5A;
        tick();
        check("edge_once", {24'h0, bus8.out}, 32'hC3);
`else
        check("load_thru_rst", {24'h0, bus8.out}, 32'hC3);
        check("load_thru_rst_valid", {31'h0, bus8.valid}, 32'h1);
        bus8.in = 8'h5A;
        tick();
        check("level_5A", {24'h0, bus8.out}, 32'h5A);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/registrador_paralelo.md
Name: registrador_paralelo

Overview:
Parallel-in/parallel-out storage register of parameterizable width. Captures the full input word on a load command and holds it on `out` until the next load, clear or reset. Used as a general-purpose holding register, for example an operand or result latch, anywhere in the datapath. Single clock domain.

Parameters:
BITS, 8, data width in bits (>= 1).
RESET_VALUE, 0, value of `out` after reset or clear; width BITS, truncated or zero-extended to BITS.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in  input  BITS  parallel data word to capture.
load  input  1  load command; capture rules are in Behaviour.
clr  input  1  synchronous clear to RESET_VALUE.
out  output  BITS  registered stored word.
valid  output  1  high once a word has been loaded since the last reset or clear.

Behaviour:
- Reset: synchronous, active-high. At the rising edge of clk with rst=1: out <= RESET_VALUE, valid <= 0.
- Priority at each rising edge: rst > clr > load > hold.
- clr=1 (rst=0): out <= RESET_VALUE, valid <= 0; any load in the same cycle is ignored.
- Capture (rst=0, clr=0, capture condition true): out <= in, valid <= 1.
- Capture condition, default build (level mode): load=1 sampled at the rising edge. A load held high for N cycles captures on every one of those N edges, so `out` tracks `in` with one-cycle latency.
- Hold: out and valid keep their values whenever no capture, clear or reset occurs.
- Latency: `in` sampled at edge k appears on `out` immediately after edge k (one clock). No combinational path from in, load or clr to out or valid.
- `in` changing while no capture occurs has no effect on `out`.
- rst asserted mid-operation overrides everything in that cycle. After release, the first capture needs a new capture condition; in edge mode, load must be seen low for at least one edge first (see Optional Feature).
- Both outputs are driven directly from flops.

Optional Feature:
Macro LOAD_EDGE_EN.
- Defined: capture only on a rising edge of load. Implementation: a flop holds load_q, the value of load at the previous clock edge; capture condition = load & ~load_q. A load held high captures exactly once, on the first edge where it is seen high. load_q resets to 1, so a load already high when reset is released does not capture. load_q updates every cycle, including cycles with clr=1.
- Undefined: level mode as described in Behaviour. The load_q flop is not instantiated.

Decomposition:
- Shared package registrador_pkg holds the default width constant (DEFAULT_BITS = 8).
- One natural sub-module: detector_borda, a single-bit synchronous rising-edge detector (inputs clk, rst, sig; output rise). Instantiated only under LOAD_EDGE_EN.
- The storage register itself stays inline in the top module.

Test Plan:
1. Reset: rst=1 for 2 cycles with in=8'hFF, load=1 -> out=8'h00, valid=0; both hold after release until a capture.
2. Basic load: in=8'h55, load=1 for one cycle -> out=8'h55, valid=1 one clock later. Then load=0 and in=8'hAA -> out stays 8'h55.
3. Reload: load=1 with in=8'hAA -> out=8'hAA next cycle. Level mode: hold load=1 and step in through 8'h01, 8'h02 -> out follows with one-cycle lag. Edge mode: out stays 8'hAA.
4. Clear priority: clr=1 and load=1 with in=8'h3C in the same cycle -> out=RESET_VALUE, valid=0. Repeat with rst=1 and clr=1 -> reset result.
5. Edge mode only: load held high through reset release -> no capture. Drop load, raise it with in=8'hC3 -> single capture, out=8'hC3.
6. Width sweep: BITS=1 and BITS=32 with RESET_VALUE=5 -> reset value 1'b1 and 32'h5 respectively. A load of all-ones captures all bits.
